alu_issue_queue: RTL and testbench
==================================

Name: alu_issue_queue

Overview:
- In-order issue queue between decode and register-read/execute for the ALU queue type (iq_type = alu).
- Buffers queue_item_t entries from decode and holds a 32-entry register scoreboard.
- Releases the head entry to the execute side when its source and destination registers are not busy and the target execution unit is ready.
- Flushes on branch mispredict.

Parameters:
- DEPTH, 8, number of queue entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- enq_valid  input  1  decode presents an item.
- enq_ready  output  1  queue can accept an item this cycle.
- enq_item  input  queue_item_t  decoded micro-op.
- iss_valid  output  1  head entry is issuable this cycle.
- iss_ready  input  1  register-read stage accepts the item.
- iss_item  output  queue_item_t  head entry.
- unit_ready  input  4  per-unit ready, indexed by exe_unit_type_t (alu, mul, div, mem).
- wb_valid  input  1  writeback completes.
- wb_rd  input  5  destination register being written back.
- flush  input  1  mispredict; discard all queued entries.
- count  output  CNT_W  current occupancy.
- sb_busy  output  32  scoreboard state, for debug.

Behaviour:
- Reset (asynchronous, active-high; clock is clk, reset is rst):
  - head, tail and count go to 0; sb_busy goes to 0.
  - enq_ready=1, iss_valid=0.
  - Entry storage is not cleared.
- Storage: circular buffer with head and tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - full = (count==DEPTH); empty = (count==0).
- Enqueue:
  - enq_ready = !full. It does not depend on iss_ready: a full queue never accepts, even if it dequeues in the same cycle.
  - On enq_valid && enq_ready: mem[tail] <= enq_item, tail++.
- Issue readiness is combinational from registered state only:
  - iss_valid = !empty
  - && !(has_rs1 && rs1!=0 && busy[rs1])
  - && !(has_rs2 && rs2!=0 && busy[rs2])
  - && !(has_rd && rd!=0 && busy[rd]) (WAW)
  - && unit_ready[exu_type].
  - iss_item = mem[head] at all times.
- Dequeue: on iss_valid && iss_ready, head++.
  - If the head has has_rd and rd!=0, set busy[rd] at the next edge.
- Latency:
  - Minimum enqueue-to-issue latency is one cycle; there is no bypass of enq_item to iss_item.
  - Writeback clears are seen by the issue check the cycle after wb_valid. There is no same-cycle wb-to-issue bypass.
- Scoreboard update:
  - wb_valid clears busy[wb_rd]. wb_rd==0 has no effect.
  - If an issue sets and a writeback clears the same register in the same cycle, set wins.
  - busy[0] is always 0.
- Count:
  - Increments on enqueue only, decrements on dequeue only.
  - Unchanged when both happen, which is possible only when not full and not empty.
- Flush (synchronous, highest priority):
  - head, tail and count go to 0.
  - Same-cycle enqueue is dropped. Same-cycle dequeue is still treated as accepted, and its scoreboard set still happens, because that op is in flight.
  - sb_busy is otherwise retained: in-flight ops still write back.
  - iss_valid is not masked by flush in the flush cycle. Downstream squashes by its own flush.
- Reset mid-operation: all state returns to reset values immediately, and no issue or enqueue completes in that cycle.
- Strict in-order: a blocked head stalls all younger entries.

Test Plan:
- Fill and drain: with iss_ready=0, enqueue 9 items (DEPTH=8) -> enq_ready=0 after the 8th, count=8, 9th held. Then set iss_ready=1 -> items issue in order, one per cycle, count reaches 0, pointers wrap correctly on a second pass of 8.
- RAW stall: issue an addi with rd=5, then enqueue an add with rs1=5 -> iss_valid=0 while busy[5]=1. Drive wb_valid, wb_rd=5 at cycle T -> add has iss_valid=1 at T+1.
- x0 and WAW: an op with rd=0 issues -> sb_busy unchanged. Issue rd=7, then enqueue another op with rd=7 -> the second op stalls until wb_rd=7.
- Unit gating: head exu_type=div with unit_ready=4'b1011 -> iss_valid=0. Set unit_ready[2]=1 -> iss_valid=1 the same cycle.
- Flush: count=5, busy[3]=1, with flush, enq_valid and a dequeue of rd=9 in the same cycle -> next cycle count=0, busy[3]=1, busy[9]=1, dropped enqueue absent.
- Set/clear collision and reset: in one cycle issue rd=4 while wb_rd=4 -> busy[4]=1 afterwards. Assert rst mid-stream -> count=0, sb_busy=0, iss_valid=0 immediately.

Source files
------------

// File: rtl/alu_issue_queue.sv
// In-order ALU issue queue with a 32-entry register scoreboard; head issues when its operands are not busy and its unit is ready.
// Latency: at least one cycle from enqueue to issue; a writeback is seen by the issue check the cycle after it.
// Backpressure: enq_ready drops when the queue is full, and a blocked head stalls every younger entry.
package alu_iq_pkg;
  typedef enum logic [1:0] {
    EXU_ALU = 2'd0,
    EXU_MUL = 2'd1,
    EXU_DIV = 2'd2,
    EXU_MEM = 2'd3
  } exe_unit_type_t;

  typedef struct packed {
    logic [7:0]     uop_id;
    exe_unit_type_t exu_type;
    logic           has_rs1;
    logic [4:0]     rs1;
    logic           has_rs2;
    logic [4:0]     rs2;
    logic           has_rd;
    logic [4:0]     rd;
    logic [31:0]    imm;
  } queue_item_t;
endpackage

module alu_issue_queue
  import alu_iq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  queue_item_t      enq_item,
  output logic             iss_valid,
  input  logic             iss_ready,
  output queue_item_t      iss_item,
  input  logic [3:0]       unit_ready,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic [31:0]      sb_busy
);
  localparam int PTR_W = $clog2(DEPTH);

  queue_item_t      mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      sb_q, sb_d;

  queue_item_t hd;
  logic        full, empty;
  logic        rs1_blk, rs2_blk, rd_blk;
  logic        enq_fire, deq_fire;

  always_comb begin
    hd        = mem_q[head_q];
    full      = (count_q == CNT_W'(DEPTH));
    empty     = (count_q == '0);
    rs1_blk   = hd.has_rs1 && (hd.rs1 != 5'd0) && sb_q[hd.rs1];
    rs2_blk   = hd.has_rs2 && (hd.rs2 != 5'd0) && sb_q[hd.rs2];
    rd_blk    = hd.has_rd  && (hd.rd  != 5'd0) && sb_q[hd.rd];
    enq_ready = !full;
    iss_valid = !empty && !rs1_blk && !rs2_blk && !rd_blk && unit_ready[hd.exu_type];
    iss_item  = hd;
    // A flush drops the incoming op, but an op leaving the head is already in flight.
    enq_fire  = enq_valid && enq_ready && !flush;
    deq_fire  = iss_valid && iss_ready;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    sb_d    = sb_q;
    if (wb_valid) sb_d[wb_rd] = 1'b0;
    // Set after clear so an issue wins a same-register collision.
    if (deq_fire && hd.has_rd) sb_d[hd.rd] = 1'b1;
    sb_d[0] = 1'b0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + PTR_W'(1);
      if (deq_fire) head_d = head_q + PTR_W'(1);
      if (enq_fire && !deq_fire) count_d = count_q + CNT_W'(1);
      else if (!enq_fire && deq_fire) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      sb_q    <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      sb_q    <= sb_d;
    end
  end

  // Payload storage is never reset; the rst term keeps a write from landing during reset.
  always_ff @(posedge clk) begin
    if (enq_fire && !rst) mem_q[tail_q] <= enq_item;
  end

  assign count   = count_q;
  assign sb_busy = sb_q;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: fill/drain, RAW/WAW stalls, unit gating, flush and reset.
module tb_alu_issue_queue;
  import alu_iq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid;
  logic        enq_ready;
  queue_item_t enq_item;
  logic        iss_valid;
  logic        iss_ready;
  queue_item_t iss_item;
  logic [3:0]  unit_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [3:0]  count;
  logic [31:0] sb_busy;

  int checks = 0;
  int failures = 0;

  alu_issue_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_item(enq_item),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_item(iss_item),
    .unit_ready(unit_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .flush(flush), .count(count), .sb_busy(sb_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic queue_item_t mk(input logic [7:0] id, input exe_unit_type_t exu,
                                     input logic h1, input logic [4:0] r1,
                                     input logic h2, input logic [4:0] r2,
                                     input logic hd, input logic [4:0] rd);
    queue_item_t it;
    it.uop_id = id; it.exu_type = exu;
    it.has_rs1 = h1; it.rs1 = r1;
    it.has_rs2 = h2; it.rs2 = r2;
    it.has_rd = hd; it.rd = rd;
    it.imm = {24'h0, id};
    return it;
  endfunction

  initial begin
    rst = 1'b1; enq_valid = 1'b0; enq_item = '0; iss_ready = 1'b0;
    unit_ready = 4'hF; wb_valid = 1'b0; wb_rd = 5'd0; flush = 1'b0;
    tick(); tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_sb", sb_busy, 32'd0);
    chk("rst_iss_valid", 32'(iss_valid), 32'd0);
    chk("rst_enq_ready", 32'(enq_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Fill: eight accepted, ninth held
    for (int i = 0; i < 8; i++) begin
      enq_valid = 1'b1; enq_item = mk(8'(i), EXU_ALU, 0, 0, 0, 0, 0, 0);
      #1 chk("fill_enq_ready", 32'(enq_ready), 32'd1);
      tick();
    end
    enq_item = mk(8'd8, EXU_ALU, 0, 0, 0, 0, 0, 0);
    #1 chk("full_enq_ready", 32'(enq_ready), 32'd0);
    chk("full_count", 32'(count), 32'd8);
    tick();
    chk("held_count", 32'(count), 32'd8);
    enq_valid = 1'b0;
    iss_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1 chk("drain_iss_valid", 32'(iss_valid), 32'd1);
      chk("drain_order", 32'(iss_item.uop_id), 32'(i));
      tick();
    end
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_iss_valid_empty", 32'(iss_valid), 32'd0);

    // Second pass: streaming enqueue and issue through the pointer wrap
    for (int k = 0; k < 9; k++) begin
      enq_valid = (k < 8);
      enq_item = mk(8'(20 + k), EXU_ALU, 0, 0, 0, 0, 0, 0);
      if (k > 0) begin
        #1 chk("stream_order", 32'(iss_item.uop_id), 32'(20 + k - 1));
        chk("stream_count", 32'(count), 32'd1);
      end
      tick();
    end
    enq_valid = 1'b0;
    chk("stream_count_end", 32'(count), 32'd0);

    // RAW: addi rd=5 issues, add rs1=5 waits for writeback
    enq_valid = 1'b1; enq_item = mk(8'd40, EXU_ALU, 0, 0, 0, 0, 1, 5);
    tick();
    enq_item = mk(8'd41, EXU_ALU, 1, 5, 0, 0, 1, 6);
    #1 chk("raw_first_issue", 32'(iss_valid), 32'd1);
    tick();
    enq_valid = 1'b0;
    #1 chk("raw_busy5", sb_busy, 32'h20);
    chk("raw_stall", 32'(iss_valid), 32'd0);
    tick();
    chk("raw_stall_hold", 32'(iss_valid), 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd5;
    #1 chk("raw_no_bypass", 32'(iss_valid), 32'd0);
    tick();
    wb_valid = 1'b0;
    #1 chk("raw_release", 32'(iss_valid), 32'd1);
    chk("raw_release_id", 32'(iss_item.uop_id), 32'd41);
    tick();
    chk("raw_busy6", sb_busy, 32'h40);
    wb_valid = 1'b1; wb_rd = 5'd0;
    tick();
    chk("wb_x0_noeffect", sb_busy, 32'h40);
    wb_rd = 5'd6;
    tick();
    wb_valid = 1'b0;
    chk("raw_clear", sb_busy, 32'd0);

    // x0 destination never marks busy; WAW on rd=7
    enq_valid = 1'b1; enq_item = mk(8'd50, EXU_ALU, 0, 0, 0, 0, 1, 0);
    tick();
    enq_valid = 1'b0;
    tick();
    chk("x0_sb", sb_busy, 32'd0);
    chk("x0_count", 32'(count), 32'd0);
    enq_valid = 1'b1; enq_item = mk(8'd51, EXU_ALU, 0, 0, 0, 0, 1, 7);
    tick();
    enq_item = mk(8'd52, EXU_ALU, 0, 0, 0, 0, 1, 7);
    tick();
    enq_valid = 1'b0;
    #1 chk("waw_busy7", sb_busy, 32'h80);
    chk("waw_stall", 32'(iss_valid), 32'd0);
    tick();
    chk("waw_stall_hold", 32'(iss_valid), 32'd0);
    wb_valid = 1'b1; wb_rd = 5'd7;
    tick();
    wb_valid = 1'b0;
    #1 chk("waw_release", 32'(iss_valid), 32'd1);
    chk("waw_release_id", 32'(iss_item.uop_id), 32'd52);
    tick();
    chk("waw_rebusy7", sb_busy, 32'h80);
    wb_valid = 1'b1; wb_rd = 5'd7;
    tick();
    wb_valid = 1'b0;

    // Unit gating: div head waits on unit_ready[2]
    iss_ready = 1'b0;
    enq_valid = 1'b1; enq_item = mk(8'd60, EXU_DIV, 0, 0, 0, 0, 0, 0);
    tick();
    enq_valid = 1'b0;
    unit_ready = 4'b1011;
    #1 chk("unit_gate", 32'(iss_valid), 32'd0);
    unit_ready = 4'b1111;
    #1 chk("unit_open", 32'(iss_valid), 32'd1);
    iss_ready = 1'b1;
    tick();
    chk("unit_count", 32'(count), 32'd0);

    // Flush with simultaneous enqueue and a dequeue of rd=9
    enq_valid = 1'b1; enq_item = mk(8'd70, EXU_ALU, 0, 0, 0, 0, 1, 3);
    tick();
    enq_valid = 1'b0;
    tick();
    iss_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enq_valid = 1'b1;
      enq_item = (i == 0) ? mk(8'd71, EXU_ALU, 0, 0, 0, 0, 1, 9) : mk(8'(71 + i), EXU_ALU, 0, 0, 0, 0, 0, 0);
      tick();
    end
    chk("pre_flush_count", 32'(count), 32'd5);
    chk("pre_flush_sb", sb_busy, 32'h8);
    enq_item = mk(8'd76, EXU_ALU, 0, 0, 0, 0, 0, 0);
    flush = 1'b1; iss_ready = 1'b1;
    #1 chk("flush_cycle_iss_valid", 32'(iss_valid), 32'd1);
    tick();
    flush = 1'b0; enq_valid = 1'b0; iss_ready = 1'b0;
    #1 chk("flush_count", 32'(count), 32'd0);
    chk("flush_sb", sb_busy, 32'h208);
    chk("flush_iss_valid", 32'(iss_valid), 32'd0);
    tick();
    chk("flush_drop_enq", 32'(count), 32'd0);

    // Same-register set/clear collision: set wins
    enq_valid = 1'b1; enq_item = mk(8'd80, EXU_ALU, 0, 0, 0, 0, 1, 4);
    tick();
    enq_valid = 1'b0; iss_ready = 1'b1; wb_valid = 1'b1; wb_rd = 5'd4;
    #1 chk("coll_iss_valid", 32'(iss_valid), 32'd1);
    tick();
    wb_valid = 1'b0; iss_ready = 1'b0;
    chk("coll_sb", sb_busy, 32'h218);

    // Reset mid-stream takes effect immediately
    enq_valid = 1'b1; enq_item = mk(8'd90, EXU_ALU, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("pre_rst_count", 32'(count), 32'd2);
    rst = 1'b1;
    #1 chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_sb", sb_busy, 32'd0);
    chk("mid_rst_iss_valid", 32'(iss_valid), 32'd0);
    chk("mid_rst_enq_ready", 32'(enq_ready), 32'd1);
    tick();
    chk("rst_hold_count", 32'(count), 32'd0);
    enq_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("post_rst_count", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
